// File: rtl/axi4_lite_read_slave_pkg.sv
// axi4_lite_read_slave_pkg: shared response codes, FSM encoding and clog2 for the AXI4-Lite slaves
package axi4_lite_read_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi4_lite_read_slave_if.sv
// axi4_lite_read_slave_if: AXI4-Lite AR + R channel bundle
//   read_addr/read_addr_valid/read_addr_ready        : AR channel (master drives addr/valid)
//   read_data/read_resp/read_data_valid/read_data_ready : R channel (slave drives data/resp/valid)
interface axi4_lite_read_slave_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] read_addr;
  logic                     read_addr_valid;
  logic                     read_addr_ready;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [1:0]               read_resp;
  logic                     read_data_valid;
  logic                     read_data_ready;
  modport master (
    output read_addr, read_addr_valid, read_data_ready,
    input  read_addr_ready, read_data, read_resp, read_data_valid
  );
  modport slave (
    input  read_addr, read_addr_valid, read_data_ready,
    output read_addr_ready, read_data, read_resp, read_data_valid
  );
endinterface

// File: rtl/axi4_lite_addr_fifo.sv
// axi4_lite_addr_fifo: synchronous address FIFO, async active-low reset
//   clk, rst_n      : clock, async active-low reset
//   push, din       : write request and data (ignored when full)
//   pop             : read request (ignored when empty)
//   full, empty     : from registered occupancy
//   head            : oldest entry, valid while !empty
module axi4_lite_addr_fifo
  import axi4_lite_read_slave_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;
  assign full    = cnt == (PW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign head    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axi4_lite_read_slave.sv
// axi4_lite_read_slave: parametrised AXI4-Lite read slave with buffered AR, decode/SLVERR and in-order R
//   axi_clk, resetn  : clock, async active-low reset
//   bus              : AR/R channels (slave modport)
//   mem_addr         : register index to the register file
//   mem_read_enable  : read strobe; register file samples mem_addr on this edge
//   mem_data_in      : register data, valid the cycle after the strobe edge
module axi4_lite_read_slave
  import axi4_lite_read_slave_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int REG_COUNT     = 4,
  parameter int FIFO_DEPTH    = 2,
  localparam int IDX_W        = clog2(REG_COUNT) < 1 ? 1 : clog2(REG_COUNT)
) (
  input  logic                  axi_clk,
  input  logic                  resetn,
  axi4_lite_read_slave_if.slave bus,
  output logic [IDX_W-1:0]      mem_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);
  localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);
  localparam int HI       = ADDR_LSB + IDX_W;
  state_t                   state, state_n;
  logic                     ar_en, ar_ready, full, empty, pop, err;
  logic [ADDRESS_WIDTH-1:0] head;
  logic [IDX_W-1:0]         idx;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_n;
  logic [1:0]               rresp_q, rresp_n;
  logic                     rvalid_q, rvalid_n;
  // ar_en holds ARREADY low until the first edge after reset release
  assign ar_ready            = ar_en && !full;
  assign bus.read_addr_ready = ar_ready;
  assign bus.read_data       = rdata_q;
  assign bus.read_resp       = rresp_q;
  assign bus.read_data_valid = rvalid_q;
  axi4_lite_addr_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (axi_clk),
    .rst_n(resetn),
    .push (bus.read_addr_valid && ar_ready),
    .pop  (pop),
    .din  (bus.read_addr),
    .full (full),
    .empty(empty),
    .head (head)
  );
  // misaligned, index past the register file, or stray upper address bits
  assign idx = head[ADDR_LSB +: IDX_W];
  assign err = (head[ADDR_LSB-1:0] != '0) || (int'(idx) >= REG_COUNT) || ((head >> HI) != '0);
  assign mem_addr = mem_read_enable ? idx : '0;
  always_comb begin
    state_n         = state;
    pop             = 1'b0;
    mem_read_enable = 1'b0;
    rdata_n         = rdata_q;
    rresp_n         = rresp_q;
    rvalid_n        = rvalid_q;
    case (state)
      S_IDLE:
        if (!empty) begin
          pop = 1'b1;
          if (err) begin
            rdata_n  = '0;
            rresp_n  = RESP_SLVERR;
            rvalid_n = 1'b1;
            state_n  = S_RESP;
          end else begin
            mem_read_enable = 1'b1;
            state_n         = S_WAIT;
          end
        end
      S_WAIT: begin
        rdata_n  = mem_data_in;
        rresp_n  = RESP_OKAY;
        rvalid_n = 1'b1;
        state_n  = S_RESP;
      end
      S_RESP:
        if (bus.read_data_ready) begin
          rvalid_n = 1'b0;
          state_n  = S_IDLE;
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge axi_clk or negedge resetn)
    if (!resetn) begin
      state    <= S_IDLE;
      ar_en    <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_n;
      ar_en    <= 1'b1;
      rdata_q  <= rdata_n;
      rresp_q  <= rresp_n;
      rvalid_q <= rvalid_n;
    end
endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// tb_axi4_lite_read_slave: directed self-checking bench for the 32-bit/4-reg and 64-bit/3-reg slaves
module tb_axi4_lite_read_slave;
  import axi4_lite_read_slave_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  axi4_lite_read_slave_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();
  axi4_lite_read_slave_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(64)) bus64 ();
  logic [1:0]  mem_addr, mem_addr64;
  logic        mem_read_enable, mem_re64;
  logic [31:0] mem_data_in = '0;
  logic [63:0] mem_data64 = '0;
  int vectors = 0;
  int miscompares = 0;
  int re_cnt = 0;
  axi4_lite_read_slave #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .REG_COUNT(4), .FIFO_DEPTH(2)) dut (
    .axi_clk(clk), .resetn(resetn), .bus(bus),
    .mem_addr(mem_addr), .mem_read_enable(mem_read_enable), .mem_data_in(mem_data_in)
  );
  axi4_lite_read_slave #(.DATA_WIDTH(64), .ADDRESS_WIDTH(8), .REG_COUNT(3), .FIFO_DEPTH(2)) dut64 (
    .axi_clk(clk), .resetn(resetn), .bus(bus64),
    .mem_addr(mem_addr64), .mem_read_enable(mem_re64), .mem_data_in(mem_data64)
  );
  // register files with one-cycle registered read: regs[i] = A0+i / C0DE0000_000000B0+i
  always @(posedge clk) begin
    if (mem_read_enable) begin
      mem_data_in <= 32'hA0 + 32'(mem_addr);
      re_cnt <= re_cnt + 1;
    end
    if (mem_re64) mem_data64 <= {32'hC0DE0000, 32'hB0 + 32'(mem_addr64)};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_one(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [1:0] r, input logic [1:0] idx);
    int k, re0;
    bus.read_addr = a;
    bus.read_addr_valid = 1'b1;
    chk({tag, "_arready"}, 64'(bus.read_addr_ready), 64'd1);
    re0 = re_cnt;
    @(negedge clk);
    bus.read_addr_valid = 1'b0;
    if (r == RESP_OKAY) begin
      chk({tag, "_mem_re"}, 64'(mem_read_enable), 64'd1);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(idx));
    end
    k = 0;
    while (!bus.read_data_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), r == RESP_OKAY ? 64'd2 : 64'd1);
    chk({tag, "_rdata"}, 64'(bus.read_data), 64'(d));
    chk({tag, "_rresp"}, 64'(bus.read_resp), 64'(r));
    chk({tag, "_re_count"}, 64'(re_cnt - re0), r == RESP_OKAY ? 64'd1 : 64'd0);
    @(negedge clk);
    chk({tag, "_rvalid_drop"}, 64'(bus.read_data_valid), 64'd0);
  endtask

  task automatic stream(input string tag, input logic [7:0] a[4], input logic [31:0] d[4],
                        input logic [1:0] r[4], input int n, input int stall, input int exp_acc);
    int ai, got;
    logic hs;
    ai = 0;
    got = 0;
    bus.read_data_ready = (stall == 0);
    for (int c = 0; c < 60 && got < n; c++) begin
      if (ai < n) begin
        bus.read_addr = a[ai];
        bus.read_addr_valid = 1'b1;
      end else bus.read_addr_valid = 1'b0;
      if (bus.read_data_valid) begin
        if (bus.read_data_ready) begin
          chk($sformatf("%s_rdata%0d", tag, got), 64'(bus.read_data), 64'(d[got]));
          chk($sformatf("%s_rresp%0d", tag, got), 64'(bus.read_resp), 64'(r[got]));
          got++;
        end else chk({tag, "_hold"}, 64'(bus.read_data), 64'(d[got]));
      end
      if (stall > 0 && c == stall - 1) begin
        chk({tag, "_ar_blocked"}, 64'(bus.read_addr_ready), 64'd0);
        chk({tag, "_accepted"}, 64'(ai), 64'(exp_acc));
      end
      hs = bus.read_addr_valid && bus.read_addr_ready;
      @(negedge clk);
      if (hs) ai++;
      if (c + 1 == stall) bus.read_data_ready = 1'b1;
    end
    bus.read_addr_valid = 1'b0;
    chk({tag, "_responses"}, 64'(got), 64'(n));
  endtask

  task automatic read64(input string tag, input logic [7:0] a, input logic [63:0] d, input logic [1:0] r);
    int k;
    bus64.read_addr = a;
    bus64.read_addr_valid = 1'b1;
    chk({tag, "_arready"}, 64'(bus64.read_addr_ready), 64'd1);
    @(negedge clk);
    bus64.read_addr_valid = 1'b0;
    k = 0;
    while (!bus64.read_data_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), r == RESP_OKAY ? 64'd2 : 64'd1);
    chk({tag, "_rdata"}, bus64.read_data, d);
    chk({tag, "_rresp"}, 64'(bus64.read_resp), 64'(r));
    @(negedge clk);
  endtask

  initial begin
    bus.read_addr = '0;
    bus.read_addr_valid = 1'b0;
    bus.read_data_ready = 1'b1;
    bus64.read_addr = '0;
    bus64.read_addr_valid = 1'b0;
    bus64.read_data_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_arready", 64'(bus.read_addr_ready), 64'd0);
    chk("rst_rvalid", 64'(bus.read_data_valid), 64'd0);
    chk("rst_rdata", 64'(bus.read_data), 64'd0);
    chk("rst_rresp", 64'(bus.read_resp), 64'd0);
    chk("rst_mem_re", 64'(mem_read_enable), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    resetn = 1'b1;
    #1 chk("release_arready_low", 64'(bus.read_addr_ready), 64'd0);
    @(negedge clk);
    chk("release_arready_high", 64'(bus.read_addr_ready), 64'd1);

    read_one("t1", 8'h08, 32'hA2, RESP_OKAY, 2'd2);
    read_one("t2_misaligned", 8'h03, 32'h0, RESP_SLVERR, 2'd0);
    read_one("t2_range", 8'h10, 32'h0, RESP_SLVERR, 2'd0);

    stream("t3", '{8'h00, 8'h04, 8'h08, 8'h0C}, '{32'hA0, 32'hA1, 32'hA2, 32'hA3},
           '{RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY}, 4, 8, 3);
    repeat (2) @(negedge clk);
    stream("t4", '{8'h04, 8'h14, 8'h0C, 8'h00}, '{32'hA1, 32'h0, 32'hA3, 32'h0},
           '{RESP_OKAY, RESP_SLVERR, RESP_OKAY, RESP_OKAY}, 3, 0, 3);
    repeat (2) @(negedge clk);

    bus.read_addr = 8'h00;
    bus.read_addr_valid = 1'b1;
    @(negedge clk);
    bus.read_addr = 8'h04;
    @(negedge clk);
    bus.read_addr_valid = 1'b0;
    chk("t5_in_wait", 64'(bus.read_data), 64'hA3);
    resetn = 1'b0;
    #1;
    chk("t5_rst_arready", 64'(bus.read_addr_ready), 64'd0);
    chk("t5_rst_rvalid", 64'(bus.read_data_valid), 64'd0);
    chk("t5_rst_rdata", 64'(bus.read_data), 64'd0);
    chk("t5_rst_rresp", 64'(bus.read_resp), 64'd0);
    chk("t5_rst_mem_re", 64'(mem_read_enable), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_resp", 64'(bus.read_data_valid), 64'd0);
    chk("t5_no_resp_data", 64'(bus.read_data), 64'd0);
    read_one("t5_fresh", 8'h00, 32'hA0, RESP_OKAY, 2'd0);

    read64("t6_ok", 8'h10, 64'hC0DE0000_000000B2, RESP_OKAY);
    read64("t6_range", 8'h18, 64'h0, RESP_SLVERR);
    read64("t6_misaligned", 8'h04, 64'h0, RESP_SLVERR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
